udp_rx_word_packer: RTL

UDP_RX_WORD_PACKER -- requirements
Module: udp_rx_word_packer

---
 rtl/udp_rx_word_packer_if.sv | 44 ++++
 rtl/udp_rx_word_packer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/udp_rx_word_packer_if.sv
// rtl/udp_rx_word_packer_if.sv - UDP header, payload byte stream and packed word stream bundle
interface udp_rx_word_packer_if #(
  parameter int DATA_W = 64
);
  localparam int BPW     = DATA_W / 8;
  localparam int BYTES_W = $clog2(BPW) + 1;

  logic               rx_udp_hdr_valid;
  logic               rx_udp_hdr_ready;
  logic [15:0]        rx_udp_dest_port;
  logic [15:0]        rx_udp_length;

  logic [7:0]         rx_udp_payload_axis_tdata;
  logic               rx_udp_payload_axis_tvalid;
  logic               rx_udp_payload_axis_tready;
  logic               rx_udp_payload_axis_tlast;
  logic               rx_udp_payload_axis_tuser;

  logic [DATA_W-1:0]  dout_data;
  logic               dout_valid;
  logic               dout_ready;
  logic               dout_last;
  logic [BYTES_W-1:0] dout_bytes;
  logic               dout_err;

  // master = surrounding environment (header/payload source, word sink)
  modport master (
    output rx_udp_hdr_valid, rx_udp_dest_port, rx_udp_length,
    output rx_udp_payload_axis_tdata, rx_udp_payload_axis_tvalid,
    output rx_udp_payload_axis_tlast, rx_udp_payload_axis_tuser,
    output dout_ready,
    input  rx_udp_hdr_ready, rx_udp_payload_axis_tready,
    input  dout_data, dout_valid, dout_last, dout_bytes, dout_err
  );

  modport slave (
    input  rx_udp_hdr_valid, rx_udp_dest_port, rx_udp_length,
    input  rx_udp_payload_axis_tdata, rx_udp_payload_axis_tvalid,
    input  rx_udp_payload_axis_tlast, rx_udp_payload_axis_tuser,
    input  dout_ready,
    output rx_udp_hdr_ready, rx_udp_payload_axis_tready,
    output dout_data, dout_valid, dout_last, dout_bytes, dout_err
  );
endinterface

// File: rtl/udp_rx_word_packer.sv
// rtl/udp_rx_word_packer.sv - packs a UDP payload byte stream MSB-first into DATA_W words
// Optional destination-port filter enabled by defining UDP_RX_PORT_FILTER_EN.
module udp_rx_word_packer #(
  parameter int DATA_W = 64
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  udp_rx_word_packer_if.slave  bus,
  input  logic [15:0]          local_port,
  output logic [15:0]          drop_count
);
  localparam int BPW     = DATA_W / 8;
  localparam int BYTES_W = $clog2(BPW) + 1;
  localparam int IDX_W   = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [15:0]         byte_cnt;
  logic [15:0]         exp_len;
  logic                err_acc;
  logic [DATA_W-1:0]   acc;

  logic [DATA_W-1:0]   dout_data_q;
  logic                dout_valid_q;
  logic                dout_last_q;
  logic [BYTES_W-1:0]  dout_bytes_q;
  logic                dout_err_q;

  logic [DATA_W-1:0]   acc_next;
  logic [15:0]         cnt_next;
  logic                word_done;
  logic                frame_err;
  logic                take;
  logic                reject;

  assign bus.rx_udp_hdr_ready = !rst && (state == IDLE);
  assign bus.rx_udp_payload_axis_tready = !rst &&
      (((state == PAYLOAD) && (!dout_valid_q || bus.dout_ready)) || (state == DROP));
  assign take = bus.rx_udp_payload_axis_tvalid && bus.rx_udp_payload_axis_tready;

  assign bus.dout_data  = dout_data_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.dout_bytes = dout_bytes_q;
  assign bus.dout_err   = dout_err_q;

`ifdef UDP_RX_PORT_FILTER_EN
  assign reject = (bus.rx_udp_dest_port != local_port);
`else
  logic unused_filter_inputs;
  assign reject = 1'b0;
  assign unused_filter_inputs = ^{bus.rx_udp_dest_port, local_port};
`endif

  always_comb begin
    acc_next = acc;
    for (int b = 0; b < BPW; b++) begin
      if (int'(idx) == b) acc_next[DATA_W-1-8*b -: 8] = bus.rx_udp_payload_axis_tdata;
    end
    cnt_next  = byte_cnt + 16'd1;
    word_done = (int'(idx) == BPW - 1) || bus.rx_udp_payload_axis_tlast;
    frame_err = err_acc || bus.rx_udp_payload_axis_tuser || (cnt_next != exp_len);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      byte_cnt     <= '0;
      exp_len      <= '0;
      err_acc      <= 1'b0;
      acc          <= '0;
      dout_data_q  <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_bytes_q <= '0;
      dout_err_q   <= 1'b0;
    end else begin
      if (dout_valid_q && bus.dout_ready) dout_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rx_udp_hdr_valid) begin
            exp_len  <= bus.rx_udp_length - 16'd8;
            idx      <= '0;
            byte_cnt <= '0;
            err_acc  <= 1'b0;
            acc      <= '0;
            state    <= reject ? DROP : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (take) begin
            byte_cnt <= cnt_next;
            err_acc  <= err_acc | bus.rx_udp_payload_axis_tuser;
            if (word_done) begin
              // accumulator is zeroed after each transfer so short words carry zero padding
              dout_data_q  <= acc_next;
              dout_bytes_q <= BYTES_W'(idx) + BYTES_W'(1);
              dout_valid_q <= 1'b1;
              dout_last_q  <= bus.rx_udp_payload_axis_tlast;
              dout_err_q   <= bus.rx_udp_payload_axis_tlast && frame_err;
              acc          <= '0;
              idx          <= '0;
              if (bus.rx_udp_payload_axis_tlast) state <= IDLE;
            end else begin
              acc <= acc_next;
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DROP: begin
          if (bus.rx_udp_payload_axis_tvalid && bus.rx_udp_payload_axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UDP_RX_PORT_FILTER_EN
  logic [15:0] drops;
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      drops <= '0;
    end else if ((state == DROP) && bus.rx_udp_payload_axis_tvalid &&
                 bus.rx_udp_payload_axis_tlast && (drops != 16'hFFFF)) begin
      drops <= drops + 16'd1;
    end
  end
  assign drop_count = drops;
`else
  assign drop_count = 16'd0;
`endif
endmodule
